// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the board input conditioner: channel FSM encoding
// and the default debounce interval.
package input_conditioner_pkg;

    // Per-channel qualification state.
    typedef enum logic {
        StStable = 1'b0,
        StCheck  = 1'b1
    } state_e;

    // 20 ms at 50 MHz.
    localparam int unsigned DefaultDebounceCycles = 1000000;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One input channel: 2-flop synchronizer, stability counter, accepted level
// and registered rise/fall pulses that line up with the new level.
module input_conditioner_debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter logic        RESET_LEVEL     = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned COUNT_WIDTH     = 24
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [COUNT_WIDTH-1:0] LastCount = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                   sync1_q, sync2_q;
    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Bring the raw asynchronous input into the clock domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Qualify a change only after it has held for DEBOUNCE_CYCLES samples.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            StStable: begin
                count_d = '0;
                if (sync2_q != level_q) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (sync2_q == level_q) begin
                    // Glitch: drop it and restart from scratch on the next change.
                    state_d = StStable;
                    count_d = '0;
                end else if (count_q == LastCount) begin
                    state_d = StStable;
                    count_d = '0;
                    level_d = sync2_q;
                    rise_d  = sync2_q;
                    fall_d  = ~sync2_q;
                end else begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end
        endcase
    end

    // Channel state; the accepted level resets to the idle input polarity.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StStable;
            count_q <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: debounces active-low pushbuttons and slide switches,
// producing clean levels plus press/release pulses for the keys.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned NUM_SWITCHES    = 10,
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned COUNT_WIDTH     = 24
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_KEYS-1:0]     key_n,
    input  logic [NUM_SWITCHES-1:0] switch_raw,
    output logic [NUM_KEYS-1:0]     key_pressed,
    output logic [NUM_KEYS-1:0]     key_press_pulse,
    output logic [NUM_KEYS-1:0]     key_release_pulse,
    output logic [NUM_SWITCHES-1:0] switch_level,
    output logic                    any_key_event
);

    logic [NUM_KEYS-1:0]     key_level;
    logic [NUM_KEYS-1:0]     key_rise;
    logic [NUM_KEYS-1:0]     key_fall;
    logic [NUM_SWITCHES-1:0] sw_rise;
    logic [NUM_SWITCHES-1:0] sw_fall;
    logic                    unused_sw_pulses;

    // Key channels run in raw (active-low) polarity, idling released.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        input_conditioner_debounce_channel #(
            .RESET_LEVEL    (1'b1),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .COUNT_WIDTH    (COUNT_WIDTH)
        ) u_chan (
            .clk_i  (clock),
            .rst_i  (reset),
            .raw_i  (key_n[i]),
            .level_o(key_level[i]),
            .rise_o (key_rise[i]),
            .fall_o (key_fall[i])
        );
    end

    for (genvar j = 0; j < NUM_SWITCHES; j++) begin : g_sw
        input_conditioner_debounce_channel #(
            .RESET_LEVEL    (1'b0),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .COUNT_WIDTH    (COUNT_WIDTH)
        ) u_chan (
            .clk_i  (clock),
            .rst_i  (reset),
            .raw_i  (switch_raw[j]),
            .level_o(switch_level[j]),
            .rise_o (sw_rise[j]),
            .fall_o (sw_fall[j])
        );
    end

    // Invert to active-high: a falling raw level is a press, a rising one a release.
    always_comb begin
        key_pressed       = ~key_level;
        key_press_pulse   = key_fall;
        key_release_pulse = key_rise;
        any_key_event     = |{key_fall, key_rise};
        unused_sw_pulses  = ^{sw_rise, sw_fall};
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with an 8-cycle debounce interval.
module tb_input_conditioner;

    logic       clock;
    logic       reset;
    logic [3:0] key_n;
    logic [9:0] switch_raw;
    logic [3:0] key_pressed;
    logic [3:0] key_press_pulse;
    logic [3:0] key_release_pulse;
    logic [9:0] switch_level;
    logic       any_key_event;

    int checks;
    int errors;

    input_conditioner #(
        .NUM_KEYS       (4),
        .NUM_SWITCHES   (10),
        .DEBOUNCE_CYCLES(8),
        .COUNT_WIDTH    (24)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .key_n            (key_n),
        .switch_raw       (switch_raw),
        .key_pressed      (key_pressed),
        .key_press_pulse  (key_press_pulse),
        .key_release_pulse(key_release_pulse),
        .switch_level     (switch_level),
        .any_key_event    (any_key_event)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and park at the following negedge for sampling.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        key_n      = 4'hf;
        switch_raw = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({key_pressed, key_press_pulse, key_release_pulse, switch_level, any_key_event} !== 23'b0) begin
            errors++;
            $display("FAIL reset_held: got %b want 0",
                {key_pressed, key_press_pulse, key_release_pulse, switch_level, any_key_event});
        end
        reset = 1'b0;
        repeat (12) step();
        checks++;
        if ({key_pressed, key_press_pulse, key_release_pulse, switch_level, any_key_event} !== 23'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b want 0",
                {key_pressed, key_press_pulse, key_release_pulse, switch_level, any_key_event});
        end
    endtask

    task automatic test_press();
        logic [12:0] exp;
        key_n = 4'b1110;
        for (int e = 0; e < 12; e++) begin
            step();
            exp = {(e >= 10) ? 4'b0001 : 4'b0000, (e == 10) ? 4'b0001 : 4'b0000, 4'b0000, e == 10};
            checks++;
            if ({key_pressed, key_press_pulse, key_release_pulse, any_key_event} !== exp) begin
                errors++;
                $display("FAIL press edge %0d: got %b want %b", e,
                    {key_pressed, key_press_pulse, key_release_pulse, any_key_event}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [12:0] exp;
        exp = {4'b0001, 4'b0000, 4'b0000, 1'b0};
        key_n = 4'b1100;
        for (int e = 0; e < 21; e++) begin
            if (e == 5) key_n = 4'b1110;
            step();
            checks++;
            if ({key_pressed, key_press_pulse, key_release_pulse, any_key_event} !== exp) begin
                errors++;
                $display("FAIL glitch edge %0d: got %b want %b", e,
                    {key_pressed, key_press_pulse, key_release_pulse, any_key_event}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [12:0] exp;
        exp = {4'b0001, 4'b0000, 4'b0000, 1'b0};
        for (int ph = 0; ph < 10; ph++) begin
            key_n = (ph % 2 == 0) ? 4'b1010 : 4'b1110;
            repeat (3) begin
                step();
                checks++;
                if ({key_pressed, key_press_pulse, key_release_pulse, any_key_event} !== exp) begin
                    errors++;
                    $display("FAIL bounce phase %0d: got %b want %b", ph,
                        {key_pressed, key_press_pulse, key_release_pulse, any_key_event}, exp);
                end
            end
        end
        key_n = 4'b1010;
        for (int e = 0; e < 12; e++) begin
            step();
            exp = {(e >= 10) ? 4'b0101 : 4'b0001, (e == 10) ? 4'b0100 : 4'b0000, 4'b0000, e == 10};
            checks++;
            if ({key_pressed, key_press_pulse, key_release_pulse, any_key_event} !== exp) begin
                errors++;
                $display("FAIL bounce_settle edge %0d: got %b want %b", e,
                    {key_pressed, key_press_pulse, key_release_pulse, any_key_event}, exp);
            end
        end
    endtask

    task automatic test_release();
        logic [12:0] exp;
        key_n = 4'b1011;
        for (int e = 0; e < 12; e++) begin
            step();
            exp = {(e >= 10) ? 4'b0100 : 4'b0101, 4'b0000, (e == 10) ? 4'b0001 : 4'b0000, e == 10};
            checks++;
            if ({key_pressed, key_press_pulse, key_release_pulse, any_key_event} !== exp) begin
                errors++;
                $display("FAIL release edge %0d: got %b want %b", e,
                    {key_pressed, key_press_pulse, key_release_pulse, any_key_event}, exp);
            end
        end
        key_n = 4'b1111;
        repeat (12) step();
        checks++;
        if ({key_pressed, key_press_pulse, key_release_pulse, any_key_event} !== 13'b0) begin
            errors++;
            $display("FAIL release_all: got %b want 0",
                {key_pressed, key_press_pulse, key_release_pulse, any_key_event});
        end
    endtask

    task automatic test_simultaneous();
        logic [12:0] exp;
        key_n = 4'b0110;
        for (int e = 0; e < 12; e++) begin
            step();
            exp = {(e >= 10) ? 4'b1001 : 4'b0000, (e == 10) ? 4'b1001 : 4'b0000, 4'b0000, e == 10};
            checks++;
            if ({key_pressed, key_press_pulse, key_release_pulse, any_key_event} !== exp) begin
                errors++;
                $display("FAIL simultaneous edge %0d: got %b want %b", e,
                    {key_pressed, key_press_pulse, key_release_pulse, any_key_event}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_check();
        logic [22:0] exp;
        key_n      = 4'b0100;
        switch_raw = 10'b0000001000;
        repeat (5) step();
        checks++;
        if (key_pressed !== 4'b1001) begin
            errors++;
            $display("FAIL mid_check_pre: got %b want 1001", key_pressed);
        end
        #2 reset = 1'b1;
        key_n = 4'hf;
        #1;
        checks++;
        if ({key_pressed, key_press_pulse, key_release_pulse, switch_level, any_key_event} !== 23'b0) begin
            errors++;
            $display("FAIL async_reset: got %b want 0",
                {key_pressed, key_press_pulse, key_release_pulse, switch_level, any_key_event});
        end
        @(negedge clock);
        reset = 1'b0;
        for (int e = 0; e < 12; e++) begin
            step();
            exp = {12'b0, (e >= 10) ? 10'b0000001000 : 10'b0, 1'b0};
            checks++;
            if ({key_pressed, key_press_pulse, key_release_pulse, switch_level, any_key_event} !== exp) begin
                errors++;
                $display("FAIL switch_after_reset edge %0d: got %b want %b", e,
                    {key_pressed, key_press_pulse, key_release_pulse, switch_level, any_key_event}, exp);
            end
        end
    endtask

    task automatic test_held_through_reset();
        logic [22:0] exp;
        key_n = 4'b0111;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int e = 0; e < 12; e++) begin
            step();
            exp = {(e >= 10) ? 4'b1000 : 4'b0000, (e == 10) ? 4'b1000 : 4'b0000, 4'b0000,
                   (e >= 10) ? 10'b0000001000 : 10'b0, e == 10};
            checks++;
            if ({key_pressed, key_press_pulse, key_release_pulse, switch_level, any_key_event} !== exp) begin
                errors++;
                $display("FAIL held_through_reset edge %0d: got %b want %b", e,
                    {key_pressed, key_press_pulse, key_release_pulse, switch_level, any_key_event}, exp);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        key_n      = 4'hf;
        switch_raw = '0;
        test_reset();
        test_press();
        test_glitch();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid_check();
        test_held_through_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
